mcs_accum_core: RTL

Parametrised successor to the 4-bit two-phase 4004-style processor. It is a single-clock accumulator core that fetches instructions nibble-wise over a multiplexed data bus, using an A/M/X instruction cycle.
Word width, address-phase count and index-register count are all generalised. It adds an explicit bus output-enable, a SYNC strobe, and a defined subset of accumulator instructions with carry.
It sits as the CPU node on the MCS-style bus next to the ROM/RAM bus models in the system testbench.

---
 rtl/mcs_pkg.sv | 29 ++
 rtl/mcs_regfile.sv | 29 ++
 rtl/mcs_accum_core.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/mcs_pkg.sv
// Shared definitions for the MCS accumulator core: phase encoding and opcodes.
package mcs_pkg;

  // Instruction-cycle phase; the address phases A1..An share ST_A and are
  // told apart by a separate phase-index counter in the core.
  typedef enum logic [2:0] {
    ST_A  = 3'd0,
    ST_M1 = 3'd1,
    ST_M2 = 3'd2,
    ST_X1 = 3'd3,
    ST_X2 = 3'd4,
    ST_X3 = 3'd5
  } phase_e;

  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] OP_INC   = 4'h6;
  localparam logic [3:0] OP_ADD   = 4'h8;
  localparam logic [3:0] OP_SUB   = 4'h9;
  localparam logic [3:0] OP_LD    = 4'hA;
  localparam logic [3:0] OP_XCH   = 4'hB;
  localparam logic [3:0] OP_LDM   = 4'hD;
  localparam logic [3:0] OP_OUT   = 4'hE;
  localparam logic [3:0] OP_GRP_F = 4'hF;

  // Sub-codes carried in OPA when the opcode is OP_GRP_F.
  localparam int unsigned F_CLC = 1;
  localparam int unsigned F_IAC = 2;

endpackage

// File: rtl/mcs_regfile.sv
// Index register file: combinational read, synchronous write, sync clear.
module mcs_regfile #(
  parameter int DATA_W = 4,
  parameter int NREG   = 16,
  localparam int IDX_W = $clog2(NREG)
) (
  input  logic              clk_1,
  input  logic              reset,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic [DATA_W-1:0] rd_data,
  input  logic              we,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [DATA_W-1:0] wr_data
);

  logic [DATA_W-1:0] regs [NREG];

  assign rd_data = regs[rd_idx];

  // Clear every register on reset, otherwise write the addressed one.
  always_ff @(posedge clk_1) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (we) begin
      regs[wr_idx] <= wr_data;
    end
  end

endmodule

// File: rtl/mcs_accum_core.sv
// Accumulator core with nibble-wise multiplexed bus fetch (A/M/X cycle).
//
// phase | meaning
// ST_A  | address phase k (a_idx), PC nibble k driven, LS nibble first
// ST_M1 | bus sampled into OPR
// ST_M2 | bus sampled into OPA, PC advances
// ST_X1 | execute; results visible from the next clock
// ST_X2 | OUT drives acc onto the bus
// ST_X3 | sync strobe, last clock of the instruction cycle
module mcs_accum_core
  import mcs_pkg::*;
#(
  parameter int DATA_W   = 4,
  parameter int ADDR_NIB = 3,
  parameter int NREG     = 16
) (
  input  logic              clk_1,
  input  logic              reset,
  input  logic [DATA_W-1:0] bus_in,
  output logic [DATA_W-1:0] bus_out,
  output logic              bus_oe,
  output logic              sync,
  output logic              carry_out,
  output logic [DATA_W-1:0] acc_out
);

  localparam int PC_W   = ADDR_NIB * DATA_W;
  localparam int AIDX_W = (ADDR_NIB > 1) ? $clog2(ADDR_NIB) : 1;
  localparam int RIDX_W = $clog2(NREG);
  localparam logic [AIDX_W-1:0] A_LAST = AIDX_W'(ADDR_NIB - 1);

  phase_e            phase, phase_nxt;
  logic [AIDX_W-1:0] a_idx, a_idx_nxt;
  logic [PC_W-1:0]   pc;
  logic [DATA_W-1:0] acc, opr, opa;
  logic              carry;

  logic [3:0]        opcode;
  logic [RIDX_W-1:0] reg_idx;
  logic [DATA_W-1:0] r_rd, rf_wdata, pc_nib;
  logic              rf_we;
  logic [DATA_W:0]   sum_add, sum_sub, sum_iac;

  assign opcode    = opr[3:0];
  assign reg_idx   = opa[RIDX_W-1:0];
  assign pc_nib    = DATA_W'(pc >> (a_idx * DATA_W));
  assign acc_out   = acc;
  assign carry_out = carry;

  // SUB adds the complement of both operand and carry: carry=1 means no borrow.
  assign sum_add = {1'b0, acc} + {1'b0, r_rd} + {{DATA_W{1'b0}}, carry};
  assign sum_sub = {1'b0, acc} + {1'b0, ~r_rd} + {{DATA_W{1'b0}}, ~carry};
  assign sum_iac = {1'b0, acc} + {{DATA_W{1'b0}}, 1'b1};

  mcs_regfile #(.DATA_W(DATA_W), .NREG(NREG)) u_regfile (
    .clk_1   (clk_1),
    .reset   (reset),
    .rd_idx  (reg_idx),
    .rd_data (r_rd),
    .we      (rf_we),
    .wr_idx  (reg_idx),
    .wr_data (rf_wdata)
  );

  // Phase and address-index registers.
  always_ff @(posedge clk_1) begin
    if (reset) begin
      phase <= ST_A;
      a_idx <= '0;
    end else begin
      phase <= phase_nxt;
      a_idx <= a_idx_nxt;
    end
  end

  // Fixed-length cycle: every phase lasts exactly one clock.
  always_comb begin
    phase_nxt = phase;
    a_idx_nxt = a_idx;
    unique case (phase)
      ST_A: begin
        if (a_idx == A_LAST) begin
          phase_nxt = ST_M1;
          a_idx_nxt = '0;
        end else begin
          a_idx_nxt = a_idx + AIDX_W'(1);
        end
      end
      ST_M1:   phase_nxt = ST_M2;
      ST_M2:   phase_nxt = ST_X1;
      ST_X1:   phase_nxt = ST_X2;
      ST_X2:   phase_nxt = ST_X3;
      ST_X3:   phase_nxt = ST_A;
      default: phase_nxt = ST_A;
    endcase
  end

  // Bus drive and sync; everything is held quiet while reset is asserted.
  always_comb begin
    bus_oe  = 1'b0;
    bus_out = '0;
    sync    = 1'b0;
    if (!reset) begin
      unique case (phase)
        ST_A: begin
          bus_oe  = 1'b1;
          bus_out = pc_nib;
        end
        ST_X2: begin
          if (opcode == OP_OUT) begin
            bus_oe  = 1'b1;
            bus_out = acc;
          end
        end
        ST_X3:   sync = 1'b1;
        default: ;
      endcase
    end
  end

  // Register-file write request for XCH and INC during execute.
  always_comb begin
    rf_we    = 1'b0;
    rf_wdata = acc;
    if (phase == ST_X1) begin
      if (opcode == OP_XCH) begin
        rf_we = 1'b1;
      end else if (opcode == OP_INC) begin
        rf_we    = 1'b1;
        rf_wdata = r_rd + 1'b1;
      end
    end
  end

  // Fetch capture, PC advance and accumulator/carry execution.
  always_ff @(posedge clk_1) begin
    if (reset) begin
      pc    <= '0;
      acc   <= '0;
      carry <= 1'b0;
      opr   <= '0;
      opa   <= '0;
    end else begin
      unique case (phase)
        ST_M1: opr <= bus_in;
        ST_M2: begin
          opa <= bus_in;
          pc  <= pc + 1'b1;
        end
        ST_X1: begin
          case (opcode)
            OP_LDM: acc <= opa;
            OP_LD:  acc <= r_rd;
            OP_XCH: acc <= r_rd;
            OP_ADD: {carry, acc} <= sum_add;
            OP_SUB: {carry, acc} <= sum_sub;
            OP_GRP_F: begin
              if (opa == DATA_W'(F_CLC)) carry <= 1'b0;
              else if (opa == DATA_W'(F_IAC)) {carry, acc} <= sum_iac;
            end
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

endmodule
